pe_load_ctrl: RTL and testbench

PE_LOAD_CTRL -- requirements
Module: pe_load_ctrl

---
 rtl/pe_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_pe_load_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_load_ctrl.sv
// PE load controller: streams weight then fmap words from a buffer
// into a PE array, then waits for MAC completion and drains psums.
module pe_load_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  full_col,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] f_base,
  input  logic [LEN_WIDTH-1:0]  w_len,
  input  logic [LEN_WIDTH-1:0]  f_len,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic                  start_config,
  output logic                  start_weight_load,
  output logic                  start_feature_load,
  output logic                  psum_out_start,
  output logic                  load_full_cloumn,
  output logic [DATA_WIDTH-1:0] weight_in,
  output logic [DATA_WIDTH-1:0] feature_in,
  output logic                  weight_in_en,
  output logic                  feature_in_en,
  input  logic                  fifo_full_filter,
  input  logic                  fifo_full_fmap,
  input  logic                  mac_finish,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_WSTART,
    S_WLOAD,
    S_FSTART,
    S_FLOAD,
    S_WAITMAC,
    S_PSUM,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] w_base_q;
  logic [ADDR_WIDTH-1:0] f_base_q;
  logic [LEN_WIDTH-1:0]  w_len_q;
  logic [LEN_WIDTH-1:0]  f_len_q;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  full_q;
  logic                  pend;

  logic                  in_w;
  logic                  in_f;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [LEN_WIDTH-1:0]  len_sel;
  logic                  ff_sel;
  logic                  rd_go;
  logic                  load_end;

  // Both load states share one counter/read path, muxed by phase
  always_comb begin
    in_w     = (state == S_WLOAD);
    in_f     = (state == S_FLOAD);
    base_sel = in_f ? f_base_q : w_base_q;
    len_sel  = in_f ? f_len_q : w_len_q;
    ff_sel   = in_f ? fifo_full_fmap
                    : fifo_full_filter;
    rd_go    = (in_w | in_f) && (cnt < len_sel)
               && !pend && !ff_sel;
    load_end = (cnt == len_sel) && !pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pend     <= 1'b0;
      w_base_q <= '0;
      f_base_q <= '0;
      w_len_q  <= '0;
      f_len_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        w_base_q <= w_base;
        f_base_q <= f_base;
        w_len_q  <= w_len;
        f_len_q  <= f_len;
        full_q   <= full_col;
      end
      if (state == S_WSTART ||
          state == S_FSTART) begin
        cnt  <= '0;
        pend <= 1'b0;
      end else if (rd_go) begin
        cnt  <= cnt + LEN_WIDTH'(1);
        pend <= 1'b1;
      end else begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_CFG;
      S_CFG:     state_nx = S_WSTART;
      S_WSTART:  state_nx = S_WLOAD;
      S_WLOAD:   if (load_end) state_nx = S_FSTART;
      S_FSTART:  state_nx = S_FLOAD;
      S_FLOAD:   if (load_end) state_nx = S_WAITMAC;
      S_WAITMAC: if (mac_finish) state_nx = S_PSUM;
      S_PSUM:    state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Data is only presented in the cycle after its read
  always_comb begin
    busy               = (state != S_IDLE);
    start_config       = (state == S_CFG);
    start_weight_load  = (state == S_WSTART);
    start_feature_load = (state == S_FSTART);
    psum_out_start     = (state == S_PSUM);
    done               = (state == S_DONE);
    load_full_cloumn   = busy & full_q;
    buf_rd_en          = rd_go;
    buf_rd_addr        = '0;
    if (rd_go)
      buf_rd_addr = base_sel + ADDR_WIDTH'(cnt);
    weight_in_en  = in_w & pend;
    feature_in_en = in_f & pend;
    weight_in     = weight_in_en ? buf_rd_data : '0;
    feature_in    = feature_in_en ? buf_rd_data : '0;
  end

endmodule

// File: tb/tb_pe_load_ctrl.sv
// Randomized bench for pe_load_ctrl: buffer model, event trace
// monitor, and a per-job expected trace built from the job params.
module tb_pe_load_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;

  localparam int EV_CFG = 32'h100000;
  localparam int EV_WS  = 32'h100001;
  localparam int EV_FS  = 32'h100002;
  localparam int EV_PS  = 32'h100003;
  localparam int EV_DN  = 32'h100004;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          full_col;
  logic [AW-1:0] w_base, f_base;
  logic [LW-1:0] w_len, f_len;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data;
  logic          start_config, start_weight_load;
  logic          start_feature_load, psum_out_start;
  logic          load_full_cloumn;
  logic [DW-1:0] weight_in, feature_in;
  logic          weight_in_en, feature_in_en;
  logic          fifo_full_filter, fifo_full_fmap;
  logic          mac_finish;
  logic          busy, done;

  always #5 clk = ~clk;

  pe_load_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .full_col(full_col),
    .w_base(w_base), .f_base(f_base),
    .w_len(w_len), .f_len(f_len),
    .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .start_config(start_config),
    .start_weight_load(start_weight_load),
    .start_feature_load(start_feature_load),
    .psum_out_start(psum_out_start),
    .load_full_cloumn(load_full_cloumn),
    .weight_in(weight_in), .feature_in(feature_in),
    .weight_in_en(weight_in_en),
    .feature_in_en(feature_in_en),
    .fifo_full_filter(fifo_full_filter),
    .fifo_full_fmap(fifo_full_fmap),
    .mac_finish(mac_finish),
    .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [256];

  // Synchronous buffer; garbage when not read
  always @(posedge clk)
    buf_rd_data <= buf_rd_en ? mem[buf_rd_addr]
                             : DW'($urandom);

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  int  trace[$];
  int  rdq[$];
  int  n_w, n_f, phase, cyc, ws_cyc, fs_cyc;
  bit  done_seen, seen_fs, prev_rd;
  bit  in_job, job_full, mac_real, mac_real_prev;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_rd = 1'b0;
      mac_real_prev = 1'b0;
    end else begin
      chk("busy", busy, in_job);
      chk("lfc", load_full_cloumn, in_job & job_full);
      if (!weight_in_en) chk("w_zero", weight_in, 0);
      if (!feature_in_en) chk("f_zero", feature_in, 0);
      if (start_config) begin
        trace.push_back(EV_CFG);
        phase = 0;
      end
      if (start_weight_load) begin
        trace.push_back(EV_WS);
        phase = 1;
        ws_cyc = cyc;
      end
      if (weight_in_en) begin
        trace.push_back(32'h10000 | 32'(weight_in));
        n_w++;
      end
      if (start_feature_load) begin
        trace.push_back(EV_FS);
        phase = 2;
        fs_cyc = cyc;
        seen_fs = 1'b1;
      end
      if (feature_in_en) begin
        trace.push_back(32'h20000 | 32'(feature_in));
        n_f++;
      end
      if (psum_out_start) begin
        trace.push_back(EV_PS);
        chk("psum_t", mac_real_prev, 1);
      end
      if (done) begin
        trace.push_back(EV_DN);
        done_seen = 1'b1;
      end
      if (buf_rd_en) begin
        rdq.push_back(32'(buf_rd_addr));
        chk("one_out", prev_rd, 0);
        chk("rd_phase", phase != 0, 1);
        if (phase == 1)
          chk("ffull_w", fifo_full_filter, 0);
        else
          chk("ffull_f", fifo_full_fmap, 0);
      end
      prev_rd = buf_rd_en;
      mac_real_prev = mac_real;
      if (done) begin
        in_job = 1'b0;
        phase = 0;
      end
    end
  end

  task automatic run_job(input logic [7:0] wb,
                         input int wl,
                         input logic [7:0] fb,
                         input int fl,
                         input bit full,
                         input int fifo_p,
                         input bit hold,
                         input int spur_p,
                         input int mdly,
                         input bit abort);
    int exp[$];
    int ea[$];
    int i;
    int mw;
    bit macd;
    bit aborted;
    logic [7:0] a;
    exp.push_back(EV_CFG);
    exp.push_back(EV_WS);
    for (int k = 0; k < wl; k++) begin
      a = wb + 8'(k);
      exp.push_back(32'h10000 | 32'(mem[a]));
      ea.push_back(32'(a));
    end
    exp.push_back(EV_FS);
    for (int k = 0; k < fl; k++) begin
      a = fb + 8'(k);
      exp.push_back(32'h20000 | 32'(mem[a]));
      ea.push_back(32'(a));
    end
    exp.push_back(EV_PS);
    exp.push_back(EV_DN);

    trace.delete();
    rdq.delete();
    n_w = 0; n_f = 0; ws_cyc = 0; fs_cyc = 0;
    done_seen = 0; seen_fs = 0;
    w_base = wb; w_len = LW'(wl);
    f_base = fb; f_len = LW'(fl);
    full_col = full;
    job_full = full;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_job = 1'b1;
    w_base = AW'($urandom);
    f_base = AW'($urandom);
    w_len = LW'($urandom);
    f_len = LW'($urandom);
    full_col = ~full;
    i = 0; mw = 0; macd = 0; aborted = 0;
    while (!done_seen && i < 600) begin
      if (abort && seen_fs && n_f >= 1) begin
        rst = 1'b1;
        in_job = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs",
            {done, buf_rd_en, buf_rd_addr,
             start_config, start_weight_load,
             start_feature_load, psum_out_start,
             load_full_cloumn, weight_in_en,
             feature_in_en, weight_in, feature_in},
            0);
        aborted = 1'b1;
        break;
      end
      if (hold)
        fifo_full_filter = (i >= 3 && i <= 7);
      else
        fifo_full_filter =
          ($urandom_range(0, 99) < fifo_p);
      fifo_full_fmap = ($urandom_range(0, 99) < fifo_p);
      start = ($urandom_range(0, 99) < spur_p);
      mac_finish = 1'b0;
      mac_real = 1'b0;
      if (seen_fs && n_f == fl) begin
        mw++;
        if (!macd && mw == 3 + mdly) begin
          mac_finish = 1'b1;
          mac_real = 1'b1;
          macd = 1'b1;
        end
      end else begin
        mac_finish = ($urandom_range(0, 99) < spur_p);
      end
      @(posedge clk); #1;
      i++;
    end
    start = 1'b0;
    mac_finish = 1'b0;
    mac_real = 1'b0;
    fifo_full_filter = 1'b0;
    fifo_full_fmap = 1'b0;
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
    end else begin
      chk("job_to", done_seen, 1);
      chk("tr_len", trace.size(), exp.size());
      for (int k = 0; k < exp.size(); k++)
        if (k < trace.size())
          chk("trace", trace[k], exp[k]);
      chk("rd_n", rdq.size(), ea.size());
      for (int k = 0; k < ea.size(); k++)
        if (k < rdq.size())
          chk("rd_addr", rdq[k], ea[k]);
      if (wl == 0)
        chk("wl0_gap", fs_cyc - ws_cyc, 2);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++)
      mem[k] = DW'($urandom);
    rst = 1'b1;
    start = 1'b0;
    full_col = 1'b0;
    w_base = '0; f_base = '0;
    w_len = '0; f_len = '0;
    fifo_full_filter = 1'b0;
    fifo_full_fmap = 1'b0;
    mac_finish = 1'b0;
    mac_real = 1'b0;
    in_job = 1'b0;
    job_full = 1'b0;
    #1;
    chk("rst0_busy", busy, 0);
    chk("rst0_outs",
        {done, buf_rd_en, buf_rd_addr,
         start_config, start_weight_load,
         start_feature_load, psum_out_start,
         load_full_cloumn, weight_in_en,
         feature_in_en, weight_in, feature_in},
        0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_job(8'h10, 3, 8'h40, 2, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    run_job(8'h20, 6, 8'h50, 3, 1'b1, 0, 1'b1, 0, 1, 1'b0);
    run_job(8'h00, 0, 8'h00, 0, 1'b1, 0, 1'b0, 0, 0, 1'b0);
    run_job(8'hFE, 4, 8'h80, 2, 1'b0, 0, 1'b0, 0, 2, 1'b0);
    run_job(8'h33, 3, 8'h70, 4, 1'b1, 0, 1'b0, 60, 8, 1'b0);
    run_job(8'h30, 2, 8'h60, 5, 1'b1, 0, 1'b0, 0, 0, 1'b1);
    run_job(8'h05, 3, 8'hFF, 3, 1'b1, 20, 1'b0, 0, 1, 1'b0);

    for (int j = 0; j < 20; j++)
      run_job(8'($urandom), $urandom_range(0, 10),
              8'($urandom), $urandom_range(0, 10),
              1'($urandom), $urandom_range(0, 60),
              1'b0, 10, $urandom_range(0, 6), 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
